// File: rtl/pipe1_id.sv
// pipe1_id: decode stage (PIPE1) sitting between fetch (PIPE0) and execute (PIPE2).
// It holds one instruction in a valid/allow pipeline register and reads the
// register file. It stalls on RAW hazards against the EX stage, and it resolves
// branches and jumps back to fetch.
// Optional build macro: PIPE1_EX_FWD_EN. It adds the ex_wdata input and forwards
// results from EX instructions that are not loads. Only EX loads then cause a stall.
//
// Handshake (valid/allow): a transfer between two stages happens on a rising
// edge when the producer's valid and the consumer's allow are both high. The
// producer must keep its payload stable while valid is high and allow is low.
// valid never depends combinationally on the allow it is paired with.
module pipe1_id #(
    parameter logic [31:0] RST_PC = 32'hbfc00000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         pipe1_valid_in,
    input  logic [32:0]  pipe1_ctrl_info_in,
    input  logic [31:0]  pipe1_data_info_in,
    output logic         pipe1_allow_in,
    output logic         pipe1_valid_out,
    input  logic         pipe1_allow_out,
    output logic [33:0]  pipe1_ctrl_info_out,
    output logic [95:0]  pipe1_data_info_out,
    output logic [4:0]   rs_addr,
    output logic [4:0]   rt_addr,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    input  logic         ex_valid,
    input  logic [4:0]   ex_dest,
    input  logic         ex_is_load,
    input  logic         ex_taken,
`ifdef PIPE1_EX_FWD_EN
    input  logic [31:0]  ex_wdata,
`endif
    output logic         br_taken,
    output logic [31:0]  branch_imm,
    output logic         j_taken,
    output logic [25:0]  j_imm,
    output logic         jr_taken,
    output logic [31:0]  jr_addr
);

    // Stage register
    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        adel_r;

    // Decode results
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        known;
    logic        use_rs_d;
    logic        use_rt_d;
    logic        is_beq;
    logic        is_bne;
    logic        is_blez;
    logic        is_bgtz;
    logic        is_regimm_br;
    logic        is_j;
    logic        is_jr;

    // Hazard / operand signals
    logic        use_rs;
    logic        use_rt;
    logic        hit_rs;
    logic        hit_rt;
    logic        hit;
    logic        stall_cond;
    logic        rdy_go;
    logic [31:0] rs_value;
    logic [31:0] rt_value;

    // Control-flow signals
    logic        is_branch;
    logic        br_cond;
    logic        fire;

    assign op      = inst_r[31:26];
    assign funct   = inst_r[5:0];
    assign rs_addr = inst_r[25:21];
    assign rt_addr = inst_r[20:16];

    // Pipeline register. A flush clears valid and wins over a simultaneous accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            pc_r    <= RST_PC;
            inst_r  <= 32'h0;
            adel_r  <= 1'b0;
        end else begin
            if (ex_taken) begin
                valid_r <= 1'b0;
            end else if (pipe1_allow_in) begin
                valid_r <= pipe1_valid_in;
            end
            if (pipe1_valid_in && pipe1_allow_in && !ex_taken) begin
                pc_r   <= pipe1_ctrl_info_in[31:0];
                adel_r <= pipe1_ctrl_info_in[32];
                inst_r <= pipe1_data_info_in;
            end
        end
    end

    // Decode the supported MIPS-I subset and the operand usage of each instruction.
    always_comb begin
        known        = 1'b0;
        use_rs_d     = 1'b0;
        use_rt_d     = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_blez      = 1'b0;
        is_bgtz      = 1'b0;
        is_regimm_br = 1'b0;
        is_j         = 1'b0;
        is_jr        = 1'b0;
        case (op)
            6'h00: begin
                use_rs_d = 1'b1;
                use_rt_d = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h0c, 6'h0d, 6'h10, 6'h11, 6'h12, 6'h13,
                    6'h18, 6'h19, 6'h1a, 6'h1b,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: known = 1'b1;
                    6'h08, 6'h09: begin
                        known = 1'b1;
                        is_jr = 1'b1;
                    end
                    default: known = 1'b0;
                endcase
            end
            6'h01: begin
                use_rs_d = 1'b1;
                if (inst_r[20:16] == 5'h00 || inst_r[20:16] == 5'h01 ||
                    inst_r[20:16] == 5'h10 || inst_r[20:16] == 5'h11) begin
                    known        = 1'b1;
                    is_regimm_br = 1'b1;
                end
            end
            6'h02, 6'h03: begin
                known = 1'b1;
                is_j  = 1'b1;
            end
            6'h04: begin
                known = 1'b1; is_beq = 1'b1; use_rs_d = 1'b1; use_rt_d = 1'b1;
            end
            6'h05: begin
                known = 1'b1; is_bne = 1'b1; use_rs_d = 1'b1; use_rt_d = 1'b1;
            end
            6'h06: begin
                known = 1'b1; is_blez = 1'b1; use_rs_d = 1'b1;
            end
            6'h07: begin
                known = 1'b1; is_bgtz = 1'b1; use_rs_d = 1'b1;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
                known    = 1'b1;
                use_rs_d = 1'b1;
            end
            6'h0f: known = 1'b1;
            6'h10: known = (inst_r[25:21] == 5'h00) || (inst_r[25:21] == 5'h04) ||
                           (inst_r == 32'h42000018);
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                known    = 1'b1;
                use_rs_d = 1'b1;
            end
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin
                known    = 1'b1;
                use_rs_d = 1'b1;
                use_rt_d = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // A fetch address error turns the instruction into a NOP for hazards and control flow.
    assign use_rs = use_rs_d & ~adel_r;
    assign use_rt = use_rt_d & ~adel_r;

    assign hit_rs = ex_valid & (ex_dest != 5'd0) & use_rs & (ex_dest == rs_addr);
    assign hit_rt = ex_valid & (ex_dest != 5'd0) & use_rt & (ex_dest == rt_addr);
    assign hit    = hit_rs | hit_rt;

`ifdef PIPE1_EX_FWD_EN
    // Only a load result is unavailable in EX. Other results are forwarded.
    assign stall_cond = ex_is_load;
    assign rs_value   = (hit_rs && !ex_is_load) ? ex_wdata : rs_data;
    assign rt_value   = (hit_rt && !ex_is_load) ? ex_wdata : rt_data;
`else
    logic unused_ex_is_load;
    assign unused_ex_is_load = ex_is_load;
    assign stall_cond = 1'b1;
    assign rs_value   = rs_data;
    assign rt_value   = rt_data;
`endif

    assign rdy_go          = ~(hit & stall_cond);
    assign pipe1_valid_out = valid_r & rdy_go;
    assign pipe1_allow_in  = ~valid_r | (rdy_go & pipe1_allow_out);

    // Evaluate the branch condition on the resolved operand values.
    always_comb begin
        br_cond = 1'b0;
        if (is_beq) begin
            br_cond = (rs_value == rt_value);
        end else if (is_bne) begin
            br_cond = (rs_value != rt_value);
        end else if (is_blez) begin
            br_cond = rs_value[31] | (rs_value == 32'h0);
        end else if (is_bgtz) begin
            br_cond = ~rs_value[31] & (rs_value != 32'h0);
        end else if (is_regimm_br) begin
            // rt[0] set selects bgez/bgezal, clear selects bltz/bltzal.
            br_cond = inst_r[16] ? ~rs_value[31] : rs_value[31];
        end
    end

    assign is_branch = is_beq | is_bne | is_blez | is_bgtz | is_regimm_br;

    // Redirects fire only in the single cycle the instruction leaves the stage.
    assign fire     = valid_r & rdy_go & pipe1_allow_out & ~ex_taken & ~adel_r;
    assign br_taken = fire & is_branch & br_cond;
    assign j_taken  = fire & is_j;
    assign jr_taken = fire & is_jr;

    assign branch_imm = {{14{inst_r[15]}}, inst_r[15:0], 2'b00};
    assign j_imm      = inst_r[25:0];
    assign jr_addr    = rs_value;

    assign pipe1_ctrl_info_out = {~known, adel_r, pc_r};
    assign pipe1_data_info_out = {inst_r, rs_value, rt_value};

endmodule

// File: tb/tb_pipe1_id.sv
// tb_pipe1_id: table-driven bench for pipe1_id with a scoreboard on the downstream handshake.
module tb_pipe1_id;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic         clk;
    logic         resetn;
    logic         valid_in;
    logic [32:0]  ctrl_in;
    logic [31:0]  data_in;
    logic         allow_in;
    logic         valid_out;
    logic         allow_out;
    logic [33:0]  ctrl_out;
    logic [95:0]  data_out;
    logic [4:0]   rs_addr;
    logic [4:0]   rt_addr;
    logic [31:0]  rs_data;
    logic [31:0]  rt_data;
    logic         ex_valid;
    logic [4:0]   ex_dest;
    logic         ex_is_load;
    logic         ex_taken;
`ifdef PIPE1_EX_FWD_EN
    logic [31:0]  ex_wdata;
`endif
    logic         br_taken;
    logic [31:0]  branch_imm;
    logic         j_taken;
    logic [25:0]  j_imm;
    logic         jr_taken;
    logic [31:0]  jr_addr;

    int checks = 0;
    int errors = 0;
    logic [129:0] exp_q[$];

    pipe1_id #(.RST_PC(RST_PC)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .pipe1_valid_in      (valid_in),
        .pipe1_ctrl_info_in  (ctrl_in),
        .pipe1_data_info_in  (data_in),
        .pipe1_allow_in      (allow_in),
        .pipe1_valid_out     (valid_out),
        .pipe1_allow_out     (allow_out),
        .pipe1_ctrl_info_out (ctrl_out),
        .pipe1_data_info_out (data_out),
        .rs_addr             (rs_addr),
        .rt_addr             (rt_addr),
        .rs_data             (rs_data),
        .rt_data             (rt_data),
        .ex_valid            (ex_valid),
        .ex_dest             (ex_dest),
        .ex_is_load          (ex_is_load),
        .ex_taken            (ex_taken),
`ifdef PIPE1_EX_FWD_EN
        .ex_wdata            (ex_wdata),
`endif
        .br_taken            (br_taken),
        .branch_imm          (branch_imm),
        .j_taken             (j_taken),
        .j_imm               (j_imm),
        .jr_taken            (jr_taken),
        .jr_addr             (jr_addr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted instruction must appear downstream in order.
    always @(negedge clk) begin
        if (resetn && valid_out && allow_out && !ex_taken) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", {ctrl_out, data_out}, 130'h0);
            end else begin
                check("sb_bundle", {ctrl_out, data_out}, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [31:0] inst;
        logic        adel;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic        ex_v;
        logic [4:0]  ex_d;
        logic        ex_ld;
        logic        stall;
        logic        br;
        logic        j;
        logic        jr;
        logic        ri;
        logic [31:0] imm;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] inst, input logic adel,
                                input logic [31:0] rs_v, input logic [31:0] rt_v,
                                input logic ex_v, input logic [4:0] ex_d, input logic ex_ld,
                                input logic stall, input logic br, input logic j,
                                input logic jr, input logic ri, input logic [31:0] imm);
        vec_t v;
        v.inst = inst; v.adel = adel; v.rs_v = rs_v; v.rt_v = rt_v;
        v.ex_v = ex_v; v.ex_d = ex_d; v.ex_ld = ex_ld; v.stall = stall;
        v.br = br; v.j = j; v.jr = jr; v.ri = ri; v.imm = imm;
        return v;
    endfunction

    // Present one instruction, accept it, and follow it through to its departure.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] pc;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
        pc = 32'hbfc0_1000 + 32'(idx) * 32'd4;
        exp_rs = v.inst[25:21];
        exp_rt = v.inst[20:16];
        @(posedge clk); #1;
        valid_in   = 1'b1;
        ctrl_in    = {v.adel, pc};
        data_in    = v.inst;
        rs_data    = v.rs_v;
        rt_data    = v.rt_v;
        ex_valid   = v.ex_v;
        ex_dest    = v.ex_d;
        ex_is_load = v.ex_ld;
        allow_out  = 1'b1;
        check("accept_allow_in", 130'(allow_in), 130'(1'b1));
        exp_q.push_back({v.ri, v.adel, pc, v.inst, v.rs_v, v.rt_v});
        @(posedge clk); #1;
        valid_in = 1'b0;
        if (v.stall) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check("stall_valid_out", 130'(valid_out), 130'(1'b0));
                check("stall_allow_in", 130'(allow_in), 130'(1'b0));
                check("stall_pulses", 130'({br_taken, j_taken, jr_taken}), 130'(3'b000));
            end
            @(posedge clk); #1;
            ex_valid = 1'b0;
        end
        @(negedge clk);
        check("valid_out", 130'(valid_out), 130'(1'b1));
        check("rs_addr", 130'(rs_addr), 130'(exp_rs));
        check("rt_addr", 130'(rt_addr), 130'(exp_rt));
        check("ri", 130'(ctrl_out[33]), 130'(v.ri));
        check("pulses", 130'({br_taken, j_taken, jr_taken}), 130'({v.br, v.j, v.jr}));
        if (v.br) check("branch_imm", 130'(branch_imm), 130'(v.imm));
        if (v.j)  check("j_imm", 130'(j_imm), 130'(v.imm[25:0]));
        if (v.jr) check("jr_addr", 130'(jr_addr), 130'(v.imm));
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_dest = 5'd0; ex_is_load = 1'b0;
        @(negedge clk);
        check("after_pulses", 130'({br_taken, j_taken, jr_taken}), 130'(3'b000));
        check("after_valid_out", 130'(valid_out), 130'(1'b0));
    endtask

    initial begin
        // inst, adel, rs, rt, ex_v, ex_d, ex_ld, stall, br, j, jr, ri, imm
        vecs[0]  = mk(32'h00221821, 0, 32'h11, 32'h22, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(32'h10220003, 0, 32'd5, 32'd5, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'h0000000c);
        vecs[2]  = mk(32'h10220003, 0, 32'd5, 32'd6, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[3]  = mk(32'h1480ffff, 0, 32'd7, 32'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'hfffffffc);
        vecs[4]  = mk(32'h04a10004, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'h00000010);
        vecs[5]  = mk(32'h04a10004, 0, 32'h80000000, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[6]  = mk(32'h04a00004, 0, 32'h80000000, 32'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'h00000010);
        vecs[7]  = mk(32'h18c00002, 0, 32'd1, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(32'h18c00002, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'h00000008);
        vecs[9]  = mk(32'h1cc00002, 0, 32'd1, 32'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 32'h00000008);
        vecs[10] = mk(32'h1cc00002, 0, 32'hffffffff, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[11] = mk(32'h08100000, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 32'h00100000);
        vecs[12] = mk(32'h0fffffff, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 32'h03ffffff);
        vecs[13] = mk(32'h03e00008, 0, 32'h80001234, 32'd0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 32'h80001234);
        vecs[14] = mk(32'h0100f809, 0, 32'h9fc00010, 32'd0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 32'h9fc00010);
        vecs[15] = mk(32'hfc000000, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[16] = mk(32'h00000001, 0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[17] = mk(32'h3c011234, 0, 32'd0, 32'd0, 1, 5'd1, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[18] = mk(32'hac220000, 0, 32'h100, 32'h55, 1, 5'd2, 1, 1, 0, 0, 0, 0, 32'h0);
        vecs[19] = mk(32'h24220005, 0, 32'h100, 32'h0, 1, 5'd2, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[20] = mk(32'h10220003, 1, 32'd5, 32'd5, 1, 5'd1, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[21] = mk(32'h1480ffff, 0, 32'd7, 32'd0, 1, 5'd4, 1, 1, 1, 0, 0, 0, 32'hfffffffc);
        vecs[22] = mk(32'h00201821, 0, 32'd9, 32'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[23] = mk(32'h00221821, 0, 32'd3, 32'd4, 0, 5'd1, 1, 0, 0, 0, 0, 0, 32'h0);

        // Reset
        resetn = 1'b0; valid_in = 1'b0; ctrl_in = '0; data_in = '0;
        allow_out = 1'b1; rs_data = '0; rt_data = '0;
        ex_valid = 1'b0; ex_dest = '0; ex_is_load = 1'b0; ex_taken = 1'b0;
`ifdef PIPE1_EX_FWD_EN
        ex_wdata = 32'hdeadbeef;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", 130'(valid_out), 130'(1'b0));
        check("rst_allow_in", 130'(allow_in), 130'(1'b1));
        check("rst_ctrl_out", 130'(ctrl_out), 130'({1'b0, 1'b0, RST_PC}));
        check("rst_data_out", 130'(data_out), 130'(96'h0));
        check("rst_pulses", 130'({br_taken, j_taken, jr_taken}), 130'(3'b000));
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Flush in the same cycle as a new accept, with a jr in ID
        @(posedge clk); #1;
        valid_in = 1'b1; ctrl_in = {1'b0, 32'hbfc02000}; data_in = 32'h03e00008;
        rs_data = 32'h80004000; rt_data = 32'h0; allow_out = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'hbfc02000, 32'h03e00008, 32'h80004000, 32'h0});
        @(posedge clk); #1;
        ctrl_in = {1'b0, 32'hbfc02004}; data_in = 32'h00221821; ex_taken = 1'b1;
        @(negedge clk);
        check("flush_allow_in", 130'(allow_in), 130'(1'b1));
        check("flush_no_jr", 130'(jr_taken), 130'(1'b0));
        @(posedge clk); #1;
        valid_in = 1'b0; ex_taken = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        check("flush_valid_out", 130'(valid_out), 130'(1'b0));
        check("flush_pc_held", 130'(ctrl_out[31:0]), 130'(32'hbfc02000));
        check("flush_after_jr", 130'(jr_taken), 130'(1'b0));

        // Downstream back-pressure with a j in ID
        @(posedge clk); #1;
        valid_in = 1'b1; ctrl_in = {1'b0, 32'hbfc03000}; data_in = 32'h08100000;
        rs_data = 32'h0; rt_data = 32'h0; allow_out = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'hbfc03000, 32'h08100000, 32'h0, 32'h0});
        @(posedge clk); #1;
        valid_in = 1'b0; allow_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_no_j", 130'(j_taken), 130'(1'b0));
            check("bp_valid_out", 130'(valid_out), 130'(1'b1));
            check("bp_allow_in", 130'(allow_in), 130'(1'b0));
            check("bp_ctrl_out", 130'(ctrl_out), 130'({1'b0, 1'b0, 32'hbfc03000}));
            check("bp_inst_out", 130'(data_out[95:64]), 130'(32'h08100000));
            @(posedge clk); #1;
        end
        allow_out = 1'b1;
        @(negedge clk);
        check("bp_j_taken", 130'(j_taken), 130'(1'b1));
        check("bp_j_imm", 130'(j_imm), 130'(26'h0100000));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_j_once", 130'(j_taken), 130'(1'b0));

        // Asynchronous reset while a taken branch is held in ID
        @(posedge clk); #1;
        valid_in = 1'b1; ctrl_in = {1'b0, 32'hbfc04000}; data_in = 32'h10220003;
        rs_data = 32'd5; rt_data = 32'd5; allow_out = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'hbfc04000, 32'h10220003, 32'd5, 32'd5});
        @(posedge clk); #1;
        valid_in = 1'b0; allow_out = 1'b0;
        #1;
        check("pre_rst_valid_out", 130'(valid_out), 130'(1'b1));
        allow_out = 1'b1; resetn = 1'b0;
        #1;
        check("mid_rst_valid_out", 130'(valid_out), 130'(1'b0));
        check("mid_rst_allow_in", 130'(allow_in), 130'(1'b1));
        check("mid_rst_br", 130'(br_taken), 130'(1'b0));
        check("mid_rst_pc", 130'(ctrl_out[31:0]), 130'(RST_PC));
        void'(exp_q.pop_front());
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_valid_out", 130'(valid_out), 130'(1'b0));

        check("sb_drained", 130'(exp_q.size()), 130'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
